// File: rtl/axi_rd_arb_2_if.sv
// AXI4 read-channel bundle (AR + R) shared by the masters and the slave.
// The master modport drives the request side; the slave modport answers it.
interface axi_rd_arb_2_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        arid;
  logic [15:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic              rready;
  logic              rvalid;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rvalid, rid, rdata, rlast
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rvalid, rid, rdata, rlast
  );
endinterface

// File: rtl/axi_rd_arb_2.sv
// Two-master round-robin arbiter in front of a single one-burst-at-a-time
// AXI4 read slave; the grant is held from AR acceptance through the last R beat.
module axi_rd_arb_2 #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  axi_rd_arb_2_if.slave   m0,
  axi_rd_arb_2_if.slave   m1,
  axi_rd_arb_2_if.master  s,
  output logic            gnt_busy,
  output logic            gnt_id
);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R
  } state_t;

  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  state_t state;
  logic   gnt;
  logic   last;

  // last resets to 1 so master 0 wins the first tie; it only moves on burst completion
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0.arvalid || m1.arvalid) begin
            gnt   <= (m0.arvalid && m1.arvalid) ? ~last : m1.arvalid;
            state <= AR;
          end
        end
        AR: begin
          if (s.arready) begin
            state <= R;
          end
        end
        R: begin
          if (s.rvalid && s.rready && s.rlast) begin
            state <= IDLE;
            last  <= gnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // AR and R paths are pure muxes on the held grant; everything idles at zero
  always_comb begin
    s.arid     = '0;
    s.araddr   = '0;
    s.arlen    = '0;
    s.arsize   = '0;
    s.arburst  = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rid     = '0;
    m0.rdata   = DATA_ZERO;
    m0.rlast   = 1'b0;
    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.rid     = '0;
    m1.rdata   = DATA_ZERO;
    m1.rlast   = 1'b0;
    case (state)
      AR: begin
        s.arvalid = 1'b1;
        if (gnt) begin
          s.arid     = m1.arid;
          s.araddr   = m1.araddr;
          s.arlen    = m1.arlen;
          s.arsize   = m1.arsize;
          s.arburst  = m1.arburst;
          m1.arready = s.arready;
        end else begin
          s.arid     = m0.arid;
          s.araddr   = m0.araddr;
          s.arlen    = m0.arlen;
          s.arsize   = m0.arsize;
          s.arburst  = m0.arburst;
          m0.arready = s.arready;
        end
      end
      R: begin
        if (gnt) begin
          s.rready  = m1.rready;
          m1.rvalid = s.rvalid;
          m1.rid    = s.rid;
          m1.rdata  = s.rdata;
          m1.rlast  = s.rlast;
        end else begin
          s.rready  = m0.rready;
          m0.rvalid = s.rvalid;
          m0.rid    = s.rid;
          m0.rdata  = s.rdata;
          m0.rlast  = s.rlast;
        end
      end
      default: ;
    endcase
  end

  assign gnt_busy = (state != IDLE);
  assign gnt_id   = gnt;

endmodule

// File: tb/tb_axi_rd_arb_2.sv
// Directed-plus-random bench for axi_rd_arb_2: a transaction-level model
// predicts the winner of each burst and the routing of every R beat.
module tb_axi_rd_arb_2;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic gnt_busy;
  logic gnt_id;

  axi_rd_arb_2_if #(.DATA_W(DATA_W)) m0_if ();
  axi_rd_arb_2_if #(.DATA_W(DATA_W)) m1_if ();
  axi_rd_arb_2_if #(.DATA_W(DATA_W)) s_if ();

  axi_rd_arb_2 #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0       (m0_if),
    .m1       (m1_if),
    .s        (s_if),
    .gnt_busy (gnt_busy),
    .gnt_id   (gnt_id)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  bit         last_served;
  bit         req [2];
  logic [3:0]  mid    [2];
  logic [15:0] maddr  [2];
  logic [7:0]  mlen   [2];
  logic [2:0]  msize  [2];
  logic [1:0]  mburst [2];

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Winner by the arbitration rule: a lone requester wins, a tie goes to whoever was not served last
  function automatic bit winner(input bit r0, input bit r1);
    if (r0 && r1) return !last_served;
    return r1;
  endfunction

  task automatic set_req(input bit n, input bit v);
    req[n] = v;
    if (n) m1_if.arvalid = v;
    else   m0_if.arvalid = v;
  endtask

  task automatic set_rready(input bit n, input bit v);
    if (n) m1_if.rready = v;
    else   m0_if.rready = v;
  endtask

  task automatic set_master(input bit n, input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len);
    mid[n]    = id;
    maddr[n]  = addr;
    mlen[n]   = len;
    msize[n]  = 3'($urandom_range(0, 5));
    mburst[n] = 2'($urandom_range(0, 2));
    if (n) begin
      m1_if.arid = id; m1_if.araddr = addr; m1_if.arlen = len;
      m1_if.arsize = msize[n]; m1_if.arburst = mburst[n];
    end else begin
      m0_if.arid = id; m0_if.araddr = addr; m0_if.arlen = len;
      m0_if.arsize = msize[n]; m0_if.arburst = mburst[n];
    end
  endtask

  task automatic apply_stimulus_reset();
    reset = 1'b0;
    set_req(0, 0); set_req(1, 0);
    set_master(0, 4'h0, 16'h0, 8'h0);
    set_master(1, 4'h0, 16'h0, 8'h0);
    m0_if.rready = 1'b0; m1_if.rready = 1'b0;
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rid = '0; s_if.rdata = '0; s_if.rlast = 1'b0;
    tick();
    tick();
    last_served = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_busy"}, gnt_busy, 0);
    check_output({tag, "_s_arvalid"}, s_if.arvalid, 0);
    check_output({tag, "_s_rready"}, s_if.rready, 0);
    check_output({tag, "_m0_arready"}, m0_if.arready, 0);
    check_output({tag, "_m1_arready"}, m1_if.arready, 0);
    check_output({tag, "_m0_rvalid"}, m0_if.rvalid, 0);
    check_output({tag, "_m1_rvalid"}, m1_if.rvalid, 0);
  endtask

  // Entered in the first AR cycle; returns in the idle turnaround cycle after the last beat
  task automatic run_burst(input bit w, input bit keep_req, input int stall_mode, input int ar_delay);
    bit o;
    int beats;
    int cyc;
    int lasts;
    logic rv, rr, rl;
    logic [DATA_W-1:0] d;
    o = !w;
    beats = 0; cyc = 0; lasts = 0;
    for (int i = 0; i <= ar_delay; i++) begin
      s_if.arready = (i == ar_delay);
      s_if.rvalid  = 1'($urandom);
      #1;
      check_output("ar_valid", s_if.arvalid, 1);
      check_output("ar_gnt_id", gnt_id, w);
      check_output("ar_busy", gnt_busy, 1);
      check_output("ar_id", s_if.arid, mid[w]);
      check_output("ar_addr", s_if.araddr, maddr[w]);
      check_output("ar_len", s_if.arlen, mlen[w]);
      check_output("ar_size_burst", {s_if.arsize, s_if.arburst}, {msize[w], mburst[w]});
      check_output("ar_ready_gnt", w ? m1_if.arready : m0_if.arready, (i == ar_delay));
      check_output("ar_ready_other", o ? m1_if.arready : m0_if.arready, 0);
      check_output("ar_s_rready", s_if.rready, 0);
      tick();
    end
    if (!keep_req) set_req(w, 0);
    s_if.arready = 1'b0;
    while (beats <= int'(mlen[w]) && cyc < 200) begin
      case (stall_mode)
        1: begin rv = ($urandom % 3) != 0; rr = ($urandom % 3) != 0; end
        2: begin rv = 1'b1; rr = !(cyc >= 1 && cyc <= 3); end
        default: begin rv = 1'b1; rr = 1'b1; end
      endcase
      rl = (beats == int'(mlen[w]));
      d  = DATA_W'($urandom);
      s_if.rvalid = rv; s_if.rid = mid[w]; s_if.rdata = d; s_if.rlast = rl;
      set_rready(w, rr);
      set_rready(o, 1'($urandom));
      #1;
      check_output("r_valid_gnt", w ? m1_if.rvalid : m0_if.rvalid, rv);
      check_output("r_data_gnt", w ? m1_if.rdata : m0_if.rdata, d);
      check_output("r_id_gnt", w ? m1_if.rid : m0_if.rid, mid[w]);
      check_output("r_last_gnt", w ? m1_if.rlast : m0_if.rlast, rl);
      check_output("r_s_rready", s_if.rready, rr);
      check_output("r_other_quiet", o ? {m1_if.rvalid, m1_if.rlast, m1_if.rid, m1_if.rdata}
                                      : {m0_if.rvalid, m0_if.rlast, m0_if.rid, m0_if.rdata}, 0);
      check_output("r_s_arvalid", s_if.arvalid, 0);
      check_output("r_busy", gnt_busy, 1);
      if ((w ? (m1_if.rvalid && m1_if.rlast) : (m0_if.rvalid && m0_if.rlast)) && rr) lasts++;
      if (rv && rr) beats++;
      cyc++;
      tick();
    end
    check_output("r_beat_count", beats, int'(mlen[w]) + 1);
    check_output("r_rlast_once", lasts, 1);
    if (stall_mode == 0) check_output("r_throughput", cyc, int'(mlen[w]) + 1);
    last_served = w;
    // Stale slave beat offered during turnaround must not be consumed
    s_if.rvalid = 1'b1; s_if.rlast = 1'b1;
    #1;
    check_idle("turn");
    s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
  endtask

  initial begin
    bit w;
    apply_stimulus_reset();
    #1;
    check_idle("in_reset");
    check_output("in_reset_gnt_id", gnt_id, 0);
    reset = 1'b1;
    tick();
    #1;
    check_idle("post_reset");
    check_output("post_reset_gnt_id", gnt_id, 0);
    check_output("post_reset_rlast", {m0_if.rlast, m1_if.rlast}, 0);

    // Single master, 4-beat burst
    set_master(0, 4'h5, 16'h3f00, 8'd3);
    set_req(0, 1);
    tick();
    run_burst(winner(req[0], req[1]), 0, 0, 0);

    // Tie straight out of reset, then the loser is served
    apply_stimulus_reset();
    reset = 1'b1;
    set_master(0, 4'($urandom), 16'($urandom), 8'($urandom_range(0, 4)));
    set_master(1, 4'($urandom), 16'($urandom), 8'($urandom_range(0, 4)));
    set_req(0, 1); set_req(1, 1);
    tick();
    w = winner(req[0], req[1]);
    run_burst(w, 0, 0, 1);
    tick();
    run_burst(winner(req[0], req[1]), 0, 0, 0);

    // Both request continuously with single-beat bursts
    set_master(0, 4'($urandom), 16'($urandom), 8'd0);
    set_master(1, 4'($urandom), 16'($urandom), 8'd0);
    set_req(0, 1); set_req(1, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      run_burst(winner(req[0], req[1]), 1, 0, 0);
    end
    set_req(0, 0); set_req(1, 0);

    // Granted master stalls for three cycles mid-burst
    set_master(1, 4'($urandom), 16'($urandom), 8'd3);
    set_req(1, 1);
    tick();
    run_burst(winner(req[0], req[1]), 0, 2, 0);

    // Random traffic with pending requests carried across bursts
    for (int it = 0; it < 8; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req[n] && ($urandom % 2) == 1) begin
          set_master(1'(n), 4'($urandom), 16'($urandom), 8'($urandom_range(0, 5)));
          set_req(1'(n), 1);
        end
      end
      if (!req[0] && !req[1]) begin
        set_master(1'(it % 2), 4'($urandom), 16'($urandom), 8'($urandom_range(0, 5)));
        set_req(1'(it % 2), 1);
      end
      tick();
      run_burst(winner(req[0], req[1]), 0, 1, int'($urandom_range(0, 2)));
    end
    set_req(0, 0); set_req(1, 0);

    // Reset during beat 2 of 4, after an m0 completion
    set_master(0, 4'($urandom), 16'($urandom), 8'd0);
    set_req(0, 1);
    tick();
    run_burst(winner(req[0], req[1]), 0, 0, 0);
    set_master(0, 4'ha, 16'h1234, 8'd3);
    set_req(0, 1);
    tick();
    s_if.arready = 1'b1;
    tick();
    set_req(0, 0);
    s_if.arready = 1'b0;
    s_if.rvalid = 1'b1; s_if.rid = 4'ha; s_if.rdata = 32'h1111_0001; s_if.rlast = 1'b0;
    m0_if.rready = 1'b1;
    tick();
    s_if.rdata = 32'h1111_0002;
    reset = 1'b0;
    #1;
    check_output("mid_beat2_valid", m0_if.rvalid, 1);
    tick();
    #1;
    check_idle("mid_reset");
    check_output("mid_reset_gnt_id", gnt_id, 0);
    last_served = 1'b1;
    reset = 1'b1;
    s_if.rvalid = 1'b0;
    set_master(0, 4'($urandom), 16'($urandom), 8'd1);
    set_master(1, 4'($urandom), 16'($urandom), 8'd1);
    set_req(0, 1); set_req(1, 1);
    tick();
    run_burst(winner(req[0], req[1]), 0, 0, 0);
    set_req(0, 0); set_req(1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
